// File: rtl/ras_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ras_pkg
// Description : Shared widths and FSM state type for the return-stack controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ras_pkg;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ras_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ras_ctrl
// Description : Sequences push/pop strobes to the hardware return stack, tracks
//               occupancy and drains speculative entries after a flush.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_ctrl
  import ras_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              call_req,
  input  logic [ADDR_W-1:0] call_addr,
  input  logic              ret_req,
  output logic              call_ack,
  output logic              ret_ack,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              ret_valid,
  input  logic              flush,
  input  logic [CNT_W-1:0]  flush_depth,
  output logic              busy,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [ADDR_W-1:0] stk_push_data,
  input  logic [ADDR_W-1:0] stk_pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow_err
);

  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_target;
  logic             r_overflow;
  logic             w_load_target;
  logic             w_ovf_set;
  logic [CNT_W:0]   w_target_p1;

  assign w_target_p1  = {1'b0, r_target} + {{CNT_W{1'b0}}, 1'b1};
  assign count        = r_count;
  assign full         = (r_count == C_DEPTH);
  assign empty        = (r_count == '0);
  assign busy         = (r_state == DRAIN);
  assign overflow_err = r_overflow;
  assign ret_addr     = stk_pop_data;

  always_comb begin
    call_ack      = 1'b0;
    ret_ack       = 1'b0;
    ret_valid     = 1'b0;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_push_data = '0;
    w_ovf_set     = 1'b0;
    w_load_target = 1'b0;
    w_next_state  = r_state;
    case (r_state)
      IDLE: begin
        if (flush) begin
          w_load_target = 1'b1;
          if (flush_depth < r_count) w_next_state = DRAIN;
        end else if (ret_req) begin
          ret_ack = 1'b1;
          if (!empty) begin
            stk_pop   = 1'b1;
            ret_valid = 1'b1;
          end
        end else if (call_req) begin
          call_ack = 1'b1;
          if (!full) begin
            stk_push      = 1'b1;
            stk_push_data = call_addr;
          end else begin
            w_ovf_set = 1'b1;
          end
        end
      end
      DRAIN: begin
        // A flush while draining only retargets; popping resumes next cycle.
        if (flush) begin
          w_load_target = 1'b1;
          w_next_state  = (flush_depth < r_count) ? DRAIN : IDLE;
        end else begin
          if (r_count > r_target) stk_pop = 1'b1;
          if ({1'b0, r_count} <= w_target_p1) w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_target   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load_target) r_target <= flush_depth;
      if (stk_push)      r_count  <= r_count + 1'b1;
      else if (stk_pop)  r_count  <= r_count - 1'b1;
      if (w_ovf_set)     r_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire
